// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and types for the arbiter and its return pipeline.
package fb_pkg;

    localparam int FB_W     = 80;
    localparam int FB_H     = 60;
    localparam int FB_DEPTH = 4800;
    localparam int ADDR_W   = 13;
    localparam int DATA_W   = 24;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    typedef struct packed {
        logic valid;
        logic is_host;
        logic is_read;
    } tag_t;

endpackage

// File: rtl/fb_arb_retpipe.sv
// Return pipeline: tracks each granted access for two cycles and steers ram_rdata
// to the display or host read port, holding each rdata between valid beats.
module fb_arb_retpipe #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_is_read,
    input  logic              s0_oob,
    input  logic              s1_valid,
    input  logic              s1_is_host,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata
);
    import fb_pkg::*;

    logic              s1_is_read_q, s1_is_read_d;
    logic              s1_oob_q, s1_oob_d;
    tag_t              s2_tag_q, s2_tag_d;
    logic              s2_oob_q, s2_oob_d;
    logic [DATA_W-1:0] disp_hold_q, disp_hold_d;
    logic [DATA_W-1:0] host_hold_q, host_hold_d;
    logic [DATA_W-1:0] ret_data;

    // Stage-1 valid/owner come from the arbiter's owner register, which already
    // records who was granted last cycle.
    always_comb begin
        s1_is_read_d     = s0_is_read;
        s1_oob_d         = s0_oob;
        s2_tag_d.valid   = s1_valid;
        s2_tag_d.is_host = s1_is_host;
        s2_tag_d.is_read = s1_is_read_q;
        s2_oob_d         = s1_oob_q;

        ret_data    = s2_oob_q ? '0 : ram_rdata;
        disp_rvalid = s2_tag_q.valid & s2_tag_q.is_read & ~s2_tag_q.is_host;
        host_rvalid = s2_tag_q.valid & s2_tag_q.is_read &  s2_tag_q.is_host;
        disp_rdata  = disp_rvalid ? ret_data : disp_hold_q;
        host_rdata  = host_rvalid ? ret_data : host_hold_q;
        disp_hold_d = disp_rdata;
        host_hold_d = host_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_is_read_q <= 1'b0;
            s1_oob_q     <= 1'b0;
            s2_tag_q     <= '0;
            s2_oob_q     <= 1'b0;
            disp_hold_q  <= '0;
            host_hold_q  <= '0;
        end else begin
            s1_is_read_q <= s1_is_read_d;
            s1_oob_q     <= s1_oob_d;
            s2_tag_q     <= s2_tag_d;
            s2_oob_q     <= s2_oob_d;
            disp_hold_q  <= disp_hold_d;
            host_hold_q  <= host_hold_d;
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Display-priority arbiter for the single-port frame-buffer RAM with bounded host starvation.
// Optional FB_ARB_ADDR_CHECK_EN blocks out-of-range accesses and raises a sticky addr_err.
module fb_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 24,
    parameter int DEPTH      = 4800,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              fifo_urgent,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              addr_err
);
    import fb_pkg::*;

    localparam int              SC_W       = $clog2(STARVE_LIM + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIM);

    if (DEPTH > (1 << ADDR_W)) begin : g_depth_chk
        $error("fb_arbiter: DEPTH does not fit in ADDR_W");
    end

    owner_t            owner_q, owner_d;
    logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              acc_any, acc_we, acc_oob;
    logic [ADDR_W-1:0] acc_addr;

    always_comb begin
        disp_gnt = 1'b0;
        host_gnt = 1'b0;
        if (!rst) begin
            if (disp_req && host_req) begin
                if (fifo_urgent)                     disp_gnt = 1'b1;
                else if (starve_cnt_q == STARVE_MAX) host_gnt = 1'b1;
                else                                 disp_gnt = 1'b1;
            end else begin
                disp_gnt = disp_req;
                host_gnt = host_req;
            end
        end
    end

`ifdef FB_ARB_ADDR_CHECK_EN
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    logic addr_err_q, addr_err_d;

    assign acc_oob    = acc_any && (acc_addr >= DEPTH_A);
    assign addr_err_d = addr_err_q | acc_oob;
    assign addr_err   = addr_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) addr_err_q <= 1'b0;
        else     addr_err_q <= addr_err_d;
    end
`else
    assign acc_oob  = 1'b0;
    assign addr_err = 1'b0;
`endif

    always_comb begin
        owner_d = disp_gnt ? OWN_DISP : (host_gnt ? OWN_HOST : OWN_IDLE);

        // Counter only measures a host wait that is still ongoing.
        starve_cnt_d = starve_cnt_q;
        if (!host_req || host_gnt)
            starve_cnt_d = '0;
        else if (disp_gnt && starve_cnt_q != STARVE_MAX)
            starve_cnt_d = starve_cnt_q + 1'b1;

        acc_any     = disp_gnt | host_gnt;
        acc_we      = host_gnt & host_we;
        acc_addr    = host_gnt ? host_addr : disp_addr;
        ram_en_d    = acc_any & ~acc_oob;
        ram_we_d    = ram_en_d & acc_we;
        ram_addr_d  = ram_en_d ? acc_addr : ram_addr_q;
        ram_wdata_d = ram_we_d ? host_wdata : ram_wdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= OWN_IDLE;
            starve_cnt_q <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

    fb_arb_retpipe #(.DATA_W(DATA_W)) u_retpipe (
        .clk         (clk),
        .rst         (rst),
        .s0_is_read  (acc_any & ~acc_we),
        .s0_oob      (acc_oob),
        .s1_valid    (owner_q != OWN_IDLE),
        .s1_is_host  (owner_q == OWN_HOST),
        .ram_rdata   (ram_rdata),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata)
    );

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed self-checking bench for fb_arbiter with a behavioural synchronous RAM.
// Address-check scenarios follow FB_ARB_ADDR_CHECK_EN when it is defined.
module tb_fb_arbiter;
    localparam int ADDR_W     = 13;
    localparam int DATA_W     = 24;
    localparam int DEPTH      = 4800;
    localparam int STARVE_LIM = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              disp_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0;
    logic              disp_gnt;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_rvalid;
    logic              fifo_urgent = 1'b0;
    logic              host_req = 1'b0;
    logic              host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              host_gnt;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic              addr_err;

    logic [DATA_W-1:0] mem [0:8191];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid), .fifo_urgent(fifo_urgent),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .addr_err(addr_err)
    );

    function automatic logic [DATA_W-1:0] pat(input int a);
        return DATA_W'(a * 32'h010101) ^ 24'h5A5A5A;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic release_all;
        disp_req = 1'b0; host_req = 1'b0; host_we = 1'b0; fifo_urgent = 1'b0;
    endtask

    task automatic test_reset;
        disp_req = 1'b1; host_req = 1'b1;
        @(posedge clk); #2;
        checks++;
        if ({disp_gnt, host_gnt} !== 2'b00) begin
            failures++;
            $display("FAIL reset_gnt got=%b exp=00", {disp_gnt, host_gnt});
        end
        release_all();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #3;
            checks++;
            if ({disp_gnt, host_gnt, ram_en, ram_we, ram_addr, ram_wdata, disp_rvalid,
                 host_rvalid, disp_rdata, host_rdata, addr_err} !== '0) begin
                failures++;
                $display("FAIL reset_idle c=%0d en=%b we=%b addr=%0d wd=%h drv=%b hrv=%b dd=%h hd=%h err=%b exp=all0",
                         c, ram_en, ram_we, ram_addr, ram_wdata, disp_rvalid, host_rvalid,
                         disp_rdata, host_rdata, addr_err);
            end
            tick();
        end
    endtask

    task automatic test_disp_reads;
        int a [3];
        a = '{0, 79, 4799};
        for (int c = 0; c < 6; c++) begin
            disp_req  = (c < 3);
            disp_addr = (c < 3) ? ADDR_W'(a[c]) : '0;
            #3;
            if (c < 3) begin
                checks++;
                if ({disp_gnt, host_gnt} !== 2'b10) begin
                    failures++;
                    $display("FAIL disp_gnt c=%0d got=%b exp=10", c, {disp_gnt, host_gnt});
                end
            end
            if (c >= 1 && c <= 3) begin
                checks++;
                if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== ADDR_W'(a[c-1])) begin
                    failures++;
                    $display("FAIL disp_ram c=%0d en=%b we=%b addr=%0d exp_addr=%0d",
                             c, ram_en, ram_we, ram_addr, a[c-1]);
                end
            end
            if (c >= 2 && c <= 4) begin
                checks++;
                if (disp_rvalid !== 1'b1 || disp_rdata !== pat(a[c-2])) begin
                    failures++;
                    $display("FAIL disp_rdata c=%0d rv=%b got=%h exp=%h", c, disp_rvalid, disp_rdata, pat(a[c-2]));
                end
            end
            if (c == 5) begin
                checks++;
                if (disp_rvalid !== 1'b0 || disp_rdata !== pat(4799)) begin
                    failures++;
                    $display("FAIL disp_hold rv=%b got=%h exp=%h", disp_rvalid, disp_rdata, pat(4799));
                end
            end
            tick();
        end
    endtask

    task automatic test_host_wr_rd;
        for (int c = 0; c < 5; c++) begin
            host_req   = (c < 2);
            host_we    = (c == 0);
            host_addr  = 13'd100;
            host_wdata = 24'hFF00FF;
            #3;
            if (c < 2) begin
                checks++;
                if ({disp_gnt, host_gnt} !== 2'b01) begin
                    failures++;
                    $display("FAIL host_gnt c=%0d got=%b exp=01", c, {disp_gnt, host_gnt});
                end
            end
            if (c == 1) begin
                checks++;
                if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 13'd100 || ram_wdata !== 24'hFF00FF) begin
                    failures++;
                    $display("FAIL host_wr_ram en=%b we=%b addr=%0d wd=%h exp=1,1,100,ff00ff",
                             ram_en, ram_we, ram_addr, ram_wdata);
                end
            end
            if (c == 2) begin
                checks++;
                if (host_rvalid !== 1'b0 || ram_we !== 1'b0) begin
                    failures++;
                    $display("FAIL host_wr_norv rv=%b we=%b exp=0,0", host_rvalid, ram_we);
                end
            end
            if (c == 3) begin
                checks++;
                if (host_rvalid !== 1'b1 || host_rdata !== 24'hFF00FF || disp_rvalid !== 1'b0) begin
                    failures++;
                    $display("FAIL host_rd rv=%b got=%h drv=%b exp=1,ff00ff,0", host_rvalid, host_rdata, disp_rvalid);
                end
            end
            tick();
        end
        release_all();
    endtask

    task automatic test_starvation;
        disp_req = 1'b1; disp_addr = 13'd3;
        host_req = 1'b1; host_we = 1'b0; host_addr = 13'd7;
        for (int c = 0; c < 10; c++) begin
            #3;
            checks++;
            if ({disp_gnt, host_gnt} !== ((c % 5 == 4) ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL starve_pattern c=%0d got=%b exp=%b", c, {disp_gnt, host_gnt},
                         (c % 5 == 4) ? 2'b01 : 2'b10);
            end
            tick();
        end
        release_all();
        repeat (3) tick();
    endtask

    task automatic test_urgent;
        disp_req = 1'b1; disp_addr = 13'd3;
        host_req = 1'b1; host_we = 1'b0; host_addr = 13'd7;
        fifo_urgent = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 8) fifo_urgent = 1'b0;
            #3;
            checks++;
            if ({disp_gnt, host_gnt} !== ((c == 8) ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL urgent c=%0d got=%b exp=%b", c, {disp_gnt, host_gnt}, (c == 8) ? 2'b01 : 2'b10);
            end
            tick();
        end
        release_all();
        repeat (3) tick();
    endtask

    task automatic test_back_to_back;
        int a [3];
        logic [DATA_W-1:0] e [3];
        a = '{100, 0, 4799};
        e[0] = 24'hFF00FF; e[1] = pat(0); e[2] = pat(4799);
        for (int c = 0; c < 5; c++) begin
            host_req  = (c < 3);
            host_we   = 1'b0;
            host_addr = (c < 3) ? ADDR_W'(a[c]) : '0;
            #3;
            if (c < 3) begin
                checks++;
                if (host_gnt !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_gnt c=%0d got=%b exp=1", c, host_gnt);
                end
            end
            if (c >= 2) begin
                checks++;
                if (host_rvalid !== 1'b1 || host_rdata !== e[c-2]) begin
                    failures++;
                    $display("FAIL b2b_rdata c=%0d rv=%b got=%h exp=%h", c, host_rvalid, host_rdata, e[c-2]);
                end
            end
            tick();
        end
        release_all();
        tick();
    endtask

    task automatic test_addr_range;
        for (int c = 0; c < 4; c++) begin
            disp_req  = (c == 0);
            disp_addr = 13'd4800;
            #3;
            if (c == 0) begin
                checks++;
                if (disp_gnt !== 1'b1) begin
                    failures++;
                    $display("FAIL oob_gnt got=%b exp=1", disp_gnt);
                end
            end
`ifdef FB_ARB_ADDR_CHECK_EN
            if (c == 1) begin
                checks++;
                if (ram_en !== 1'b0 || addr_err !== 1'b1) begin
                    failures++;
                    $display("FAIL oob_block en=%b err=%b exp=0,1", ram_en, addr_err);
                end
            end
            if (c == 2) begin
                checks++;
                if (disp_rvalid !== 1'b1 || disp_rdata !== '0) begin
                    failures++;
                    $display("FAIL oob_rdata rv=%b got=%h exp=1,000000", disp_rvalid, disp_rdata);
                end
            end
            if (c == 3) begin
                checks++;
                if (addr_err !== 1'b1) begin
                    failures++;
                    $display("FAIL oob_sticky got=%b exp=1", addr_err);
                end
            end
`else
            if (c == 1) begin
                checks++;
                if (ram_en !== 1'b1 || ram_addr !== 13'd4800 || addr_err !== 1'b0) begin
                    failures++;
                    $display("FAIL oob_pass en=%b addr=%0d err=%b exp=1,4800,0", ram_en, ram_addr, addr_err);
                end
            end
            if (c == 2) begin
                checks++;
                if (disp_rvalid !== 1'b1 || disp_rdata !== pat(4800) || addr_err !== 1'b0) begin
                    failures++;
                    $display("FAIL oob_pass_rd rv=%b got=%h err=%b exp=1,%h,0", disp_rvalid, disp_rdata, addr_err, pat(4800));
                end
            end
`endif
            tick();
        end
        release_all();
    endtask

    task automatic test_reset_mid_read;
        disp_req = 1'b1; disp_addr = 13'd5;
        #3;
        checks++;
        if (disp_gnt !== 1'b1) begin
            failures++;
            $display("FAIL midrst_gnt got=%b exp=1", disp_gnt);
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (disp_gnt !== 1'b0 || ram_en !== 1'b0 || addr_err !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async gnt=%b en=%b err=%b exp=0,0,0", disp_gnt, ram_en, addr_err);
        end
        tick();
        disp_req = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #3;
            checks++;
            if (disp_rvalid !== 1'b0 || disp_rdata !== '0 || ram_en !== 1'b0) begin
                failures++;
                $display("FAIL midrst_drop c=%0d rv=%b rd=%h en=%b exp=0,0,0", c, disp_rvalid, disp_rdata, ram_en);
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = pat(i);
        test_reset();
        test_disp_reads();
        test_host_wr_rd();
        test_starvation();
        test_urgent();
        test_back_to_back();
        test_addr_range();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
